// File: rtl/byte_unpacker_if.sv
// Handshake bundle for byte_unpacker: packed-word input, length request, token output.
interface byte_unpacker_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 8
);
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [LEN_WIDTH-1:0]  req_len;
   logic                  req_valid;
   logic                  req_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [LEN_WIDTH-1:0]  out_len;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output in_data, in_valid, req_len, req_valid, out_ready,
      input  in_ready, req_ready, out_data, out_len, out_valid
   );

   modport slave (
      input  in_data, in_valid, req_len, req_valid, out_ready,
      output in_ready, req_ready, out_data, out_len, out_valid
   );
endinterface

// File: rtl/byte_unpacker.sv
// Splits a packed MSB-first byte stream into variable-length tokens (1..N bytes each).
// Optional: define BYTE_UNPACKER_ERR_EN to reject illegal lengths and raise a sticky err.
module byte_unpacker #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   byte_unpacker_if.slave bus
`ifdef BYTE_UNPACKER_ERR_EN
   ,
   output logic err
`endif
);
   localparam int unsigned N     = DATA_WIDTH / 8;
   localparam int unsigned BUF_W = 2 * DATA_WIDTH;
   localparam int unsigned CNT_W = $clog2(2 * N + 1);

   logic [BUF_W-1:0]      buffer;
   logic [BUF_W-1:0]      buf_next;
   logic [CNT_W-1:0]      byte_cnt;
   logic [CNT_W-1:0]      cnt_next;
   logic [CNT_W-1:0]      eff_len;
   logic [CNT_W-1:0]      consumed;
   logic [CNT_W-1:0]      remain;
   logic [DATA_WIDTH-1:0] tok_mask;
   logic [DATA_WIDTH-1:0] tok_data;
   logic                  over;
   logic                  legal;
   logic                  out_free;
   logic                  req_fire;
   logic                  in_fire;

   // Consume-then-append datapath; ready signals depend on this cycle's consumption.
   always_comb begin
      over     = bus.req_len > LEN_WIDTH'(N);
      eff_len  = over ? CNT_W'(N) : CNT_W'(bus.req_len);
`ifdef BYTE_UNPACKER_ERR_EN
      legal    = !over && (bus.req_len != '0);
`else
      legal    = 1'b1;
`endif
      out_free      = !bus.out_valid || bus.out_ready;
      bus.req_ready = !flush && out_free && (!legal || (byte_cnt >= eff_len));
      req_fire      = bus.req_valid && bus.req_ready;
      consumed      = (req_fire && legal) ? eff_len : '0;
      remain        = byte_cnt - consumed;
      bus.in_ready  = !flush && (remain <= CNT_W'(N));
      in_fire       = bus.in_valid && bus.in_ready;

      buf_next = buffer << {consumed, 3'b000};
      cnt_next = remain;
      if (in_fire) begin
         buf_next = buf_next | ({bus.in_data, {DATA_WIDTH{1'b0}}} >> {remain, 3'b000});
         cnt_next = remain + CNT_W'(N);
      end

      tok_mask = ~({DATA_WIDTH{1'b1}} >> {eff_len, 3'b000});
      tok_data = buffer[BUF_W-1 -: DATA_WIDTH] & tok_mask;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buffer        <= '0;
         byte_cnt      <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_len   <= '0;
`ifdef BYTE_UNPACKER_ERR_EN
         err           <= 1'b0;
`endif
      end else begin
         if (flush) begin
            buffer   <= '0;
            byte_cnt <= '0;
         end else begin
            buffer   <= buf_next;
            byte_cnt <= cnt_next;
         end

         // A new token may replace the one being handed off in the same cycle.
         if (req_fire && legal) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= tok_data;
            bus.out_len   <= LEN_WIDTH'(eff_len);
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
`ifdef BYTE_UNPACKER_ERR_EN
         if (req_fire && !legal) begin
            err <= 1'b1;
         end
`endif
      end
   end
endmodule

// File: tb/tb_byte_unpacker.sv
// Directed scoreboard bench for byte_unpacker (DATA_WIDTH=32, LEN_WIDTH=8).
module tb_byte_unpacker;
   typedef struct packed {
      logic [31:0] data;
      logic [7:0]  len;
   } tok_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
`ifdef BYTE_UNPACKER_ERR_EN
   logic err;
`endif
   int   checks = 0;
   int   failures = 0;
   tok_t sb[$];

   byte_unpacker_if #(.DATA_WIDTH(32), .LEN_WIDTH(8)) bus ();

   byte_unpacker #(.DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
      .clk  (clk),
      .rst  (rst),
      .flush(flush),
      .bus  (bus.slave)
`ifdef BYTE_UNPACKER_ERR_EN
      ,
      .err  (err)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted output beat is matched against the oldest expectation.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat: got %h/%0d expected none", bus.out_data, bus.out_len);
         end else begin
            tok_t e;
            e = sb.pop_front();
            chk("beat_data", 64'(bus.out_data), 64'(e.data));
            chk("beat_len", 64'(bus.out_len), 64'(e.len));
         end
      end
   end

   task automatic send_word(input logic [31:0] d);
      int n = 0;
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("in_accept", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic send_req(input logic [7:0] len, input logic [31:0] d, input logic [7:0] l,
                           input bit beat);
      int   n = 0;
      tok_t e;
      e.data = d;
      e.len  = l;
      if (beat) sb.push_back(e);
      bus.req_len   = len;
      bus.req_valid = 1'b1;
      @(negedge clk);
      while (!bus.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("req_accept", 64'(bus.req_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      chk("req_latency", 64'(bus.out_valid), 64'(beat));
   endtask

   task automatic expect_drained(input string name);
      bus.req_len = 8'd1;
      @(negedge clk);
      chk(name, 64'(bus.req_ready), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_data   = '0;
      bus.in_valid  = 1'b0;
      bus.req_len   = 8'd1;
      bus.req_valid = 1'b0;
      bus.out_ready = 1'b1;

      // Reset state, then first cycle after release
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_data", 64'(bus.out_data), 64'd0);
      chk("rst_out_len", 64'(bus.out_len), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("post_rst_req_ready", 64'(bus.req_ready), 64'd0);
      @(posedge clk);
      #1;

      // Single word split 1,2,1
      send_word(32'hAABBCCDD);
      send_req(8'd1, 32'hAA000000, 8'd1, 1'b1);
      send_req(8'd2, 32'hBBCC0000, 8'd2, 1'b1);
      send_req(8'd1, 32'hDD000000, 8'd1, 1'b1);
      expect_drained("drained_a");

      // Tokens straddling word boundaries
      send_word(32'h11223344);
      send_word(32'h55667788);
      send_req(8'd3, 32'h11223300, 8'd3, 1'b1);
      send_req(8'd3, 32'h44556600, 8'd3, 1'b1);
      send_req(8'd2, 32'h77880000, 8'd2, 1'b1);
      expect_drained("drained_b");

      // Output backpressure
      bus.out_ready = 1'b0;
      send_word(32'h01020304);
      send_req(8'd2, 32'h01020000, 8'd2, 1'b1);
      repeat (5) begin
         @(negedge clk);
         chk("bp_data_stable", 64'(bus.out_data), 64'h01020000);
         chk("bp_req_blocked", 64'(bus.req_ready), 64'd0);
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      send_req(8'd2, 32'h03040000, 8'd2, 1'b1);
      expect_drained("drained_c");

      // Simultaneous consume and append at byte_cnt=4
      send_word(32'hDEADBEEF);
      sb.push_back('{data: 32'hDEADBEEF, len: 8'd4});
      bus.in_data   = 32'hCAFEF00D;
      bus.in_valid  = 1'b1;
      bus.req_len   = 8'd4;
      bus.req_valid = 1'b1;
      @(negedge clk);
      chk("both_in_ready", 64'(bus.in_ready), 64'd1);
      chk("both_req_ready", 64'(bus.req_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.req_valid = 1'b0;
      send_req(8'd4, 32'hCAFEF00D, 8'd4, 1'b1);
      expect_drained("drained_d");

      // Full buffer (2N bytes): input blocked unless N bytes are consumed
      send_word(32'h0A0B0C0D);
      send_word(32'h0E0F1011);
      bus.in_data  = 32'h12131415;
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk("full_in_blocked", 64'(bus.in_ready), 64'd0);
      bus.req_len   = 8'd1;
      bus.req_valid = 1'b1;
      #1 chk("full_partial_consume", 64'(bus.in_ready), 64'd0);
      sb.push_back('{data: 32'h0A0B0C0D, len: 8'd4});
      bus.req_len = 8'd4;
      #1 chk("full_word_consume", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.req_valid = 1'b0;
      send_req(8'd4, 32'h0E0F1011, 8'd4, 1'b1);
      send_req(8'd4, 32'h12131415, 8'd4, 1'b1);
      expect_drained("drained_e");

      // Illegal lengths
      send_word(32'h21222324);
`ifdef BYTE_UNPACKER_ERR_EN
      send_req(8'd5, 32'h0, 8'd0, 1'b0);
      chk("err_set", 64'(err), 64'd1);
      send_req(8'd0, 32'h0, 8'd0, 1'b0);
      send_req(8'd4, 32'h21222324, 8'd4, 1'b1);
`else
      send_req(8'd5, 32'h21222324, 8'd4, 1'b1);
      send_word(32'h31323334);
      send_req(8'd0, 32'h00000000, 8'd0, 1'b1);
      send_req(8'd4, 32'h31323334, 8'd4, 1'b1);
`endif
      expect_drained("drained_f");

      // Flush keeps the pending beat but drops buffered bytes
      bus.out_ready = 1'b0;
      send_word(32'h41424344);
      send_req(8'd1, 32'h41000000, 8'd1, 1'b1);
      flush         = 1'b1;
      bus.in_data   = 32'h99999999;
      bus.in_valid  = 1'b1;
      bus.req_len   = 8'd1;
      bus.req_valid = 1'b1;
      @(negedge clk);
      chk("flush_in_blocked", 64'(bus.in_ready), 64'd0);
      chk("flush_req_blocked", 64'(bus.req_ready), 64'd0);
      @(posedge clk);
      #1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.req_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("flush_beat_kept", 64'(bus.out_valid), 64'd1);
      chk("flush_emptied", 64'(bus.req_ready), 64'd0);
      @(posedge clk);
      #1;

      // Asynchronous reset mid-stream with a pending beat
      bus.out_ready = 1'b0;
      send_word(32'h51525354);
      send_req(8'd1, 32'h51000000, 8'd1, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
      chk("async_rst_data", 64'(bus.out_data), 64'd0);
      sb.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      bus.out_ready = 1'b1;
      bus.req_len   = 8'd1;
      @(negedge clk);
      chk("rst2_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst2_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst2_out_valid", 64'(bus.out_valid), 64'd0);
`ifdef BYTE_UNPACKER_ERR_EN
      chk("rst2_err", 64'(err), 64'd0);
`endif
      repeat (2) @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
